// File: rtl/dmem_responder_if.sv
// Load/store request and response bundle between the MEM stage and its data memory.
// The MEM stage drives through the master modport and the memory responds through the slave.
interface dmem_responder_if #(
    parameter int unsigned WORD_LEN = 32
);
    logic                req_valid;
    logic                req_we;
    logic [WORD_LEN-1:0] req_addr;
    logic [WORD_LEN-1:0] req_wdata;
    logic                req_ready;
    logic                resp_valid;
    logic [WORD_LEN-1:0] resp_rdata;
    logic                resp_err;
    logic                stall;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, stall
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, stall
    );
endinterface

// File: rtl/dmem_responder.sv
// Data memory behind the MEM stage, with a fixed access latency and a one-cycle response pulse.
// While a request is outstanding it asks the pipeline to freeze.
module dmem_responder #(
    parameter int unsigned WORD_LEN  = 32,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned ADDR_BASE = 1024,
    parameter int unsigned LATENCY   = 2
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);
    localparam int unsigned         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WORD_LEN-1:0] BASE     = WORD_LEN'(ADDR_BASE);
    localparam logic [WORD_LEN-1:0] DEPTH_W  = WORD_LEN'(DEPTH);
    localparam logic [3:0]          CNT_INIT = 4'((LATENCY >= 2) ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q;
    logic [WORD_LEN-1:0] addr_q;
    logic [WORD_LEN-1:0] wdata_q;
    logic                err_q;
    logic [WORD_LEN-1:0] rdata_q;
    logic [WORD_LEN-1:0] mem [DEPTH];

    logic                accept;
    logic                commit;
    logic                sel_we;
    logic [WORD_LEN-1:0] sel_addr;
    logic [WORD_LEN-1:0] sel_wdata;
    logic [WORD_LEN-1:0] sel_off;
    logic [WORD_LEN-1:0] sel_word;
    logic [IDX_W-1:0]    sel_idx;
    logic                sel_err;

    // With LATENCY=1 the commit edge is the accept edge, so the live request must be used.
    always_comb begin
        accept    = (state_q == StIdle) && bus.req_valid;
        sel_we    = (state_q == StIdle) ? bus.req_we    : we_q;
        sel_addr  = (state_q == StIdle) ? bus.req_addr  : addr_q;
        sel_wdata = (state_q == StIdle) ? bus.req_wdata : wdata_q;
        sel_off   = sel_addr - BASE;
        sel_word  = sel_off >> 2;
        sel_idx   = sel_word[IDX_W-1:0];
        sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr < BASE) || (sel_word >= DEPTH_W);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    if (LATENCY == 1) begin
                        state_d = StResp;
                    end else begin
                        state_d = StBusy;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            StBusy: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        commit = (state_d == StResp) && (state_q != StResp);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                err_q   <= sel_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (commit) begin
            rdata_q <= (!sel_we && !sel_err) ? mem[sel_idx] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (commit && sel_we && !sel_err) begin
            mem[sel_idx] <= sel_wdata;
        end
    end

    assign bus.req_ready  = (state_q == StIdle);
    assign bus.resp_valid = (state_q == StResp);
    assign bus.resp_err   = (state_q == StResp) && err_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.stall      = bus.req_valid && (state_q != StResp);
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance driven from a vector table and
// a LATENCY=1 instance driven with a back-to-back stream.
module tb_dmem_responder;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    dmem_responder_if #(.WORD_LEN(32)) if_a ();
    dmem_responder_if #(.WORD_LEN(32)) if_b ();

    dmem_responder #(
        .WORD_LEN (32),
        .DEPTH    (64),
        .ADDR_BASE(1024),
        .LATENCY  (2)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(if_a.slave)
    );

    dmem_responder #(
        .WORD_LEN (32),
        .DEPTH    (64),
        .ADDR_BASE(1024),
        .LATENCY  (1)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] busy_addr;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[13];

    logic        s_we[4];
    logic [31:0] s_addr[4];
    logic [31:0] s_wdata[4];
    logic [31:0] s_rdata[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Starts just after a rising edge; returns just after the edge that ends RESP.
    task automatic access_a(input vec_t v, input int k);
        if_a.req_valid = 1'b1;
        if_a.req_we    = v.we;
        if_a.req_addr  = v.addr;
        if_a.req_wdata = v.wdata;
        @(negedge clk);
        chk($sformatf("v%0d stall_t0", k), 32'(if_a.stall), 32'd1);
        chk($sformatf("v%0d ready_t0", k), 32'(if_a.req_ready), 32'd1);
        chk($sformatf("v%0d resp_t0", k), 32'(if_a.resp_valid), 32'd0);
        @(posedge clk);
        #1;
        if_a.req_addr  = v.busy_addr;
        if_a.req_wdata = ~v.wdata;
        @(negedge clk);
        chk($sformatf("v%0d stall_t1", k), 32'(if_a.stall), 32'd1);
        chk($sformatf("v%0d ready_t1", k), 32'(if_a.req_ready), 32'd0);
        chk($sformatf("v%0d resp_t1", k), 32'(if_a.resp_valid), 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d resp_t2", k), 32'(if_a.resp_valid), 32'd1);
        chk($sformatf("v%0d err_t2", k), 32'(if_a.resp_err), 32'(v.exp_err));
        chk($sformatf("v%0d rdata_t2", k), if_a.resp_rdata, v.exp_rdata);
        chk($sformatf("v%0d stall_t2", k), 32'(if_a.stall), 32'd0);
        @(posedge clk);
        #1;
        if_a.req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        if_a.req_valid = 1'b0;
        if_a.req_we    = 1'b0;
        if_a.req_addr  = '0;
        if_a.req_wdata = '0;
        if_b.req_valid = 1'b0;
        if_b.req_we    = 1'b0;
        if_b.req_addr  = '0;
        if_b.req_wdata = '0;

        //            we    addr           wdata          busy_addr      rdata          err
        vecs[0]  = '{1'b0, 32'd1024,      32'h0,         32'd1024,      32'h0,         1'b0};
        vecs[1]  = '{1'b1, 32'd1028,      32'hDEADBEEF,  32'd1028,      32'h0,         1'b0};
        vecs[2]  = '{1'b0, 32'd1028,      32'h0,         32'd1028,      32'hDEADBEEF,  1'b0};
        vecs[3]  = '{1'b1, 32'd1030,      32'h00001234,  32'd1030,      32'h0,         1'b1};
        vecs[4]  = '{1'b0, 32'd1028,      32'h0,         32'd1028,      32'hDEADBEEF,  1'b0};
        vecs[5]  = '{1'b0, 32'd1020,      32'h0,         32'd1020,      32'h0,         1'b1};
        vecs[6]  = '{1'b0, 32'd1280,      32'h0,         32'd1280,      32'h0,         1'b1};
        vecs[7]  = '{1'b1, 32'd1276,      32'hA5A5A5A5,  32'd1276,      32'h0,         1'b0};
        vecs[8]  = '{1'b0, 32'd1276,      32'h0,         32'd1276,      32'hA5A5A5A5,  1'b0};
        vecs[9]  = '{1'b1, 32'd1024,      32'h00000077,  32'd1024,      32'h0,         1'b0};
        vecs[10] = '{1'b0, 32'd1024,      32'h0,         32'd1028,      32'h00000077,  1'b0};
        vecs[11] = '{1'b0, 32'd0,         32'h0,         32'd0,         32'h0,         1'b1};
        vecs[12] = '{1'b0, 32'hFFFFFFFC,  32'h0,         32'hFFFFFFFC,  32'h0,         1'b1};

        s_we[0] = 1'b0; s_addr[0] = 32'd1028; s_wdata[0] = 32'h0;  s_rdata[0] = 32'h0;
        s_we[1] = 1'b1; s_addr[1] = 32'd1028; s_wdata[1] = 32'h11; s_rdata[1] = 32'h0;
        s_we[2] = 1'b0; s_addr[2] = 32'd1028; s_wdata[2] = 32'h0;  s_rdata[2] = 32'h11;
        s_we[3] = 1'b0; s_addr[3] = 32'd1032; s_wdata[3] = 32'h0;  s_rdata[3] = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst ready", 32'(if_a.req_ready), 32'd1);
        chk("rst resp_valid", 32'(if_a.resp_valid), 32'd0);
        chk("rst resp_err", 32'(if_a.resp_err), 32'd0);
        chk("rst rdata", if_a.resp_rdata, 32'h0);
        chk("rst stall", 32'(if_a.stall), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            access_a(vecs[i], i);
        end

        @(negedge clk);
        chk("idle stall", 32'(if_a.stall), 32'd0);
        chk("idle resp_valid", 32'(if_a.resp_valid), 32'd0);
        chk("idle ready", 32'(if_a.req_ready), 32'd1);

        // Reset while a store is in BUSY: the store is lost and no response appears
        @(posedge clk);
        #1;
        if_a.req_valid = 1'b1;
        if_a.req_we    = 1'b1;
        if_a.req_addr  = 32'd1032;
        if_a.req_wdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        chk("rstbusy busy_ready", 32'(if_a.req_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rstbusy ready", 32'(if_a.req_ready), 32'd1);
        chk("rstbusy resp_valid", 32'(if_a.resp_valid), 32'd0);
        if_a.req_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rstbusy resp_c%0d", c), 32'(if_a.resp_valid), 32'd0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        access_a('{1'b0, 32'd1032, 32'h0, 32'd1032, 32'h0, 1'b0}, 20);
        access_a('{1'b0, 32'd1028, 32'h0, 32'd1028, 32'h0, 1'b0}, 21);

        // Reset during RESP drops the pulse at once
        if_a.req_valid = 1'b1;
        if_a.req_we    = 1'b0;
        if_a.req_addr  = 32'd1024;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rstresp pulse", 32'(if_a.resp_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk("rstresp dropped", 32'(if_a.resp_valid), 32'd0);
        if_a.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // LATENCY=1: back-to-back stream, response every other cycle
        for (int i = 0; i < 4; i++) begin
            if_b.req_valid = 1'b1;
            if_b.req_we    = s_we[i];
            if_b.req_addr  = s_addr[i];
            if_b.req_wdata = s_wdata[i];
            @(negedge clk);
            chk($sformatf("l1 s%0d stall_acc", i), 32'(if_b.stall), 32'd1);
            chk($sformatf("l1 s%0d ready_acc", i), 32'(if_b.req_ready), 32'd1);
            chk($sformatf("l1 s%0d resp_acc", i), 32'(if_b.resp_valid), 32'd0);
            @(negedge clk);
            chk($sformatf("l1 s%0d stall_resp", i), 32'(if_b.stall), 32'd0);
            chk($sformatf("l1 s%0d ready_resp", i), 32'(if_b.req_ready), 32'd0);
            chk($sformatf("l1 s%0d resp", i), 32'(if_b.resp_valid), 32'd1);
            chk($sformatf("l1 s%0d err", i), 32'(if_b.resp_err), 32'd0);
            chk($sformatf("l1 s%0d rdata", i), if_b.resp_rdata, s_rdata[i]);
            @(posedge clk);
            #1;
        end
        if_b.req_valid = 1'b0;
        @(negedge clk);
        chk("l1 idle stall", 32'(if_b.stall), 32'd0);
        chk("l1 idle resp", 32'(if_b.resp_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder serving the MEM stage's load/store requests over a valid/ready handshake with a configurable access latency. It replaces the single-cycle data memory behind the MEM stage. It raises `stall` while an access is outstanding so the pipeline freezes. It returns read data, or write completion, as a one-cycle response pulse.

## Interface

Parameters:
- `WORD_LEN`, 32: data and address width.
- `DEPTH`, 64: number of storage words.
- `ADDR_BASE`, 1024: byte address mapped to word 0.
- `LATENCY`, 2: cycles from request acceptance to response; legal range 1..15.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset; asynchronous assert, active-low.
- `req_valid`, in, 1: request present (MEM_R_EN | MEM_W_EN of the MEM stage).
- `req_we`, in, 1: 1 = store, 0 = load.
- `req_addr`, in, WORD_LEN: byte address (ALU result).
- `req_wdata`, in, WORD_LEN: store data.
- `req_ready`, out, 1: responder can accept a request this cycle.
- `resp_valid`, out, 1: one-cycle completion pulse.
- `resp_rdata`, out, WORD_LEN: load data; valid only with `resp_valid`.
- `resp_err`, out, 1: qualifies `resp_valid`; request was misaligned or out of range.
- `stall`, out, 1: freeze request to the hazard/freeze network.

## Operation

- FSM states are IDLE, BUSY and RESP. Reset state is IDLE.
- IDLE:
  - `req_ready`=1.
  - If `req_valid`, latch we/addr/wdata and compute the error flag.
  - If LATENCY=1, go to RESP. Otherwise go to BUSY with counter = LATENCY-2.
- BUSY:
  - `req_ready`=0.
  - If counter=0, go to RESP; else decrement.
  - `req_valid`/`req_addr` changes are ignored, because the latched request completes.
- Commit happens on the edge entering RESP:
  - Store: `mem[idx] <= wdata` unless error.
  - Load: `resp_rdata <= mem[idx]`, or 0 on error or store.
- RESP: `resp_valid`=1 and `resp_err`=latched flag for exactly one cycle, then IDLE unconditionally.
- Word index: `idx = (addr - ADDR_BASE) >> 2`, using unsigned subtraction modulo 2^WORD_LEN.
- Error conditions: `addr[1:0] != 0`, `addr < ADDR_BASE`, or `idx >= DEPTH`. An errored store never modifies storage.
- `stall = req_valid & ~resp_valid`, combinational:
  - It is high from the acceptance cycle through BUSY.
  - It is low in RESP, so the pipeline advances on the RESP edge.
  - It is low whenever `req_valid`=0.
- Only one outstanding request exists at a time; there is no queueing.

## Timing

- Reset (rst=0, asynchronous):
  - FSM=IDLE, counter=0.
  - `req_ready`=1, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0.
  - All DEPTH storage words cleared to 0.
- Latency: a request accepted in cycle T has `resp_valid` high in cycle T+LATENCY.
- Throughput: one request per LATENCY+1 cycles. The cycle after RESP is IDLE and can accept at once.
- Read-after-write to the same word in back-to-back requests returns the new data, since the store commits before the following request is accepted.
- Reset asserted during BUSY aborts the access:
  - A store not yet at its commit edge is lost.
  - No `resp_valid` is produced.
- Reset asserted during RESP drops the pulse immediately.
- After rst deasserts, the first accept is possible on the first rising edge.
- `req_valid` low in IDLE gives `stall`=0 and no state change.

## Test plan

- Reset check: hold rst=0, release, then load 1024 with LATENCY=2. Require `stall`=1 in cycles T and T+1, `resp_valid`=1 in T+2 with rdata=0 and err=0, and `stall`=0 in T+2.
- Store then load: store 0xDEADBEEF to 1028, then load 1028 immediately after RESP. Require rdata=0xDEADBEEF, each access taking 3 cycles with LATENCY=2.
- Error cases:
  - Misaligned store of 0x1234 to 1030 gives `resp_err`=1, and a later load of 1028 still returns the old value.
  - A load of 1020 gives err=1 and rdata=0.
  - A load of 1024+4*DEPTH gives err=1.
- Reset during store: accept a store of 0x55 to 1032 and assert rst in BUSY. Require `resp_valid` never pulses and a later load of 1032 returns 0.
- LATENCY=1 build: a back-to-back load stream to 1024, 1028, 1032 gives `resp_valid` every other cycle. The `stall` pattern is 1,0,1,0, and `req_ready` is 0 exactly in the RESP cycles.
- Address change in BUSY: change `req_addr` from 1024 to 1028 mid-BUSY. Require the response to reflect 1024.
